// File: rtl/calc_engine_if.sv
// Keypad, register-file read port and status bundle for calc_engine.
// master drives keys and read address; slave is the engine.
interface calc_engine_if #(
   parameter int WIDTH = 16,
   parameter int AW    = 3
);
   logic             key_valid_i;
   logic [3:0]       key_code_i;
   logic [AW-1:0]    rd_addr_i;
   logic [WIDTH-1:0] rd_data_o;
   logic [WIDTH-1:0] disp_value_o;
   logic [WIDTH-1:0] result_o;
   logic             done_o;
   logic             busy_o;
   logic [AW-1:0]    wr_ptr_o;
   logic [2:0]       error_o;

   modport master (
      output key_valid_i, key_code_i, rd_addr_i,
      input  rd_data_o, disp_value_o, result_o,
      input  done_o, busy_o, wr_ptr_o, error_o
   );

   modport slave (
      input  key_valid_i, key_code_i, rd_addr_i,
      output rd_data_o, disp_value_o, result_o,
      output done_o, busy_o, wr_ptr_o, error_o
   );
endinterface

// File: rtl/calc_engine.sv
// Keypad calculator: decimal entry, add/sub/and/or, result register file.
// Define CALC_FLAGS_EN to add the carry_o/zero_o flag outputs.
module calc_engine #(
   parameter int WIDTH    = 16,
   parameter int NUM_REGS = 8,
   parameter int DIGITS   = 4
) (
   input  logic         clk,
   input  logic         reset_i,
`ifdef CALC_FLAGS_EN
   output logic         carry_o,
   output logic         zero_o,
`endif
   calc_engine_if.slave cif
);
   localparam int AW = $clog2(NUM_REGS);
   localparam logic [3:0] DIG = 4'(DIGITS);

   typedef enum logic [2:0] {
      S_OPA, S_OPB, S_EXEC, S_WB, S_ERR
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] entry_q, entry_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [1:0]       op_q, op_d;
   logic [2:0]       err_q, err_d;
   logic [WIDTH-1:0] alu_q, alu_d;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] rd_q;
   logic [AW-1:0]    wr_ptr_q;
   logic [WIDTH-1:0] rf_q [NUM_REGS];

   logic             kv;
   logic [3:0]       kc;
   logic             is_dig, is_op, is_eq, is_clr;
   logic [WIDTH+3:0] prod;
   logic [WIDTH:0]   ext;
   logic             ovf;
   logic             we;

   assign kv     = cif.key_valid_i;
   assign kc     = cif.key_code_i;
   assign is_dig = kc <= 4'd9;
   assign is_op  = kc >= 4'hA && kc <= 4'hD;
   assign is_eq  = kc == 4'hE;
   assign is_clr = kc == 4'hF;

   // entry*10 + digit, with 4 spare bits to catch value overflow
   assign prod = ({4'b0, entry_q} << 3) + ({4'b0, entry_q} << 1)
               + {{WIDTH{1'b0}}, kc};

   // op encoding follows key code: 10 add, 11 sub, 00 and, 01 or
   always_comb begin
      ext = '0;
      unique case (op_q)
         2'b10: ext = {1'b0, a_q} + {1'b0, b_q};
         2'b11: ext = {1'b0, a_q} - {1'b0, b_q};
         2'b00: ext = {1'b0, a_q & b_q};
         2'b01: ext = {1'b0, a_q | b_q};
      endcase
   end

   assign ovf = op_q[1] & ext[WIDTH];

`ifdef CALC_FLAGS_EN
   logic carry_q, carry_d, zero_q, zero_d;
`endif

   always_comb begin
      state_d = state_q;
      entry_d = entry_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      err_d   = err_q;
      alu_d   = alu_q;
      we      = 1'b0;
`ifdef CALC_FLAGS_EN
      carry_d = carry_q;
      zero_d  = zero_q;
`endif
      unique case (state_q)
         S_OPA, S_OPB: begin
            if (kv) begin
               unique case (1'b1)
                  is_dig: begin
                     if (cnt_q >= DIG || |prod[WIDTH+3:WIDTH]) begin
                        state_d = S_ERR;
                        err_d   = 3'd1;
                     end else begin
                        entry_d = prod[WIDTH-1:0];
                        cnt_d   = cnt_q + 4'd1;
                     end
                  end
                  is_op: begin
                     if (state_q == S_OPB) begin
                        op_d = kc[1:0];
                     end else if (cnt_q != 4'd0) begin
                        a_d     = entry_q;
                        op_d    = kc[1:0];
                        entry_d = '0;
                        cnt_d   = '0;
                        state_d = S_OPB;
                     end else begin
                        state_d = S_ERR;
                        err_d   = 3'd2;
                     end
                  end
                  is_eq: begin
                     if (state_q == S_OPB) begin
                        if (cnt_q != 4'd0) begin
                           b_d     = entry_q;
                           state_d = S_EXEC;
                        end else begin
                           state_d = S_ERR;
                           err_d   = 3'd4;
                        end
                     end
                  end
                  is_clr: state_d = S_OPA;
               endcase
            end
         end
         S_EXEC: begin
`ifdef CALC_FLAGS_EN
            carry_d = ovf;
            zero_d  = ext[WIDTH-1:0] == '0;
`endif
            if (ovf) begin
               state_d = S_ERR;
               err_d   = 3'd3;
            end else begin
               alu_d   = ext[WIDTH-1:0];
               state_d = S_WB;
            end
         end
         S_WB: begin
            we      = 1'b1;
            entry_d = '0;
            cnt_d   = '0;
            state_d = S_OPA;
         end
         S_ERR: if (kv && is_clr) state_d = S_OPA;
         default: state_d = S_OPA;
      endcase
      // clear is only honoured outside EXEC/WB
      if (kv && is_clr && state_q != S_EXEC && state_q != S_WB) begin
         entry_d = '0;
         cnt_d   = '0;
         a_d     = '0;
         b_d     = '0;
         op_d    = '0;
         err_d   = '0;
`ifdef CALC_FLAGS_EN
         carry_d = 1'b0;
         zero_d  = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         state_q  <= S_OPA;
         entry_q  <= '0;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         err_q    <= '0;
         alu_q    <= '0;
         res_q    <= '0;
         rd_q     <= '0;
         wr_ptr_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         entry_q <= entry_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         err_q   <= err_d;
         alu_q   <= alu_d;
         rd_q    <= rf_q[cif.rd_addr_i];
         if (we) begin
            rf_q[wr_ptr_q] <= alu_q;
            res_q          <= alu_q;
            wr_ptr_q       <= wr_ptr_q + 1'b1;
         end
      end
   end

`ifdef CALC_FLAGS_EN
   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         carry_q <= carry_d;
         zero_q  <= zero_d;
      end
   end

   assign carry_o = carry_q;
   assign zero_o  = zero_q;
`endif

   // ERR keeps showing the offending entry so the user sees what overflowed
   assign cif.disp_value_o = (state_q == S_EXEC || state_q == S_WB)
                           ? res_q : entry_q;
   assign cif.rd_data_o = rd_q;
   assign cif.result_o  = res_q;
   assign cif.done_o    = state_q == S_WB;
   assign cif.busy_o    = state_q == S_EXEC || state_q == S_WB;
   assign cif.wr_ptr_o  = wr_ptr_q;
   assign cif.error_o   = err_q;
endmodule

// File: tb/tb_calc_engine.sv
// Directed-vector bench for calc_engine (default parameters).
// Define CALC_FLAGS_EN to also exercise carry_o/zero_o.
module tb_calc_engine;
   logic clk;
   logic reset_i;
   int   n_chk;
   int   n_err;

`ifdef CALC_FLAGS_EN
   logic carry_o, zero_o;
`endif

   calc_engine_if #(.WIDTH(16), .AW(3)) cif ();

   calc_engine #(.WIDTH(16), .NUM_REGS(8), .DIGITS(4)) dut (
      .clk     (clk),
      .reset_i (reset_i),
`ifdef CALC_FLAGS_EN
      .carry_o (carry_o),
      .zero_o  (zero_o),
`endif
      .cif     (cif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   // key held for one rising edge; returns at the following negedge
   task automatic press(input logic [3:0] k);
      @(negedge clk);
      cif.key_valid_i = 1'b1;
      cif.key_code_i  = k;
      @(negedge clk);
      cif.key_valid_i = 1'b0;
      cif.key_code_i  = 4'h0;
   endtask

   task automatic num(input int v);
      string s;
      s = $sformatf("%0d", v);
      for (int i = 0; i < s.len(); i++) press(4'(s[i] - "0"));
   endtask

   task automatic calc(input int a, input logic [3:0] op, input int b);
      num(a);
      press(op);
      num(b);
      press(4'hE);
   endtask

   // call right after the equals press: done must rise exactly 2 cycles later
   task automatic expect_wb(input string tag, input int res, input int ptr);
      chk({tag, "_done_early"}, 32'(cif.done_o), 0);
      @(negedge clk);
      chk({tag, "_done"}, 32'(cif.done_o), 1);
      @(negedge clk);
      chk({tag, "_res"}, 32'(cif.result_o), 32'(res));
      chk({tag, "_ptr"}, 32'(cif.wr_ptr_o), 32'(ptr));
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] a,
                         input int exp);
      cif.rd_addr_i = a;
      @(negedge clk);
      chk(tag, 32'(cif.rd_data_o), 32'(exp));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_i = 1'b0;
      @(negedge clk);
      reset_i = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      reset_i = 1'b0;
      cif.key_valid_i = 1'b0;
      cif.key_code_i  = 4'h0;
      cif.rd_addr_i   = 3'd0;
      repeat (3) @(negedge clk);
      chk("rst_err", 32'(cif.error_o), 0);
      chk("rst_res", 32'(cif.result_o), 0);
      chk("rst_ptr", 32'(cif.wr_ptr_o), 0);
      chk("rst_done", 32'(cif.done_o), 0);
      chk("rst_busy", 32'(cif.busy_o), 0);
      chk("rst_disp", 32'(cif.disp_value_o), 0);
      chk("rst_rd", 32'(cif.rd_data_o), 0);
      reset_i = 1'b1;
      @(negedge clk);

      // 12 + 3
      num(12);
      press(4'hA);
      num(3);
      chk("add_disp_b", 32'(cif.disp_value_o), 3);
      press(4'hE);
      chk("add_busy", 32'(cif.busy_o), 1);
      expect_wb("add", 15, 1);
      chk("add_disp_opa", 32'(cif.disp_value_o), 0);
      rd_chk("add_rf0", 3'd0, 15);

      calc(9, 4'hB, 5);
      expect_wb("sub", 4, 2);
      calc(12, 4'hC, 10);
      expect_wb("and", 8, 3);
      calc(12, 4'hD, 3);
      expect_wb("or", 15, 4);
      // second operator replaces add by sub
      press(4'h8);
      press(4'hA);
      press(4'hB);
      press(4'h3);
      press(4'hE);
      expect_wb("oprepl", 5, 5);
      rd_chk("rf2", 3'd2, 8);
      rd_chk("rf4", 3'd4, 5);

      press(4'hA);
      chk("err2", 32'(cif.error_o), 2);
      press(4'hF);
      chk("err2_clr", 32'(cif.error_o), 0);

      press(4'h3);
      press(4'hA);
      press(4'hE);
      chk("err4", 32'(cif.error_o), 4);
      press(4'hF);

      press(4'h5);
      press(4'hE);
      chk("eq_opa_busy", 32'(cif.busy_o), 0);
      chk("eq_opa_err", 32'(cif.error_o), 0);
      chk("eq_opa_disp", 32'(cif.disp_value_o), 5);
      press(4'hF);

      // 5 - 9 borrows
      calc(5, 4'hB, 9);
      chk("brw_busy", 32'(cif.busy_o), 1);
      @(negedge clk);
      chk("brw_err", 32'(cif.error_o), 3);
      chk("brw_done", 32'(cif.done_o), 0);
`ifdef CALC_FLAGS_EN
      chk("brw_carry", 32'(carry_o), 1);
`endif
      @(negedge clk);
      chk("brw_done2", 32'(cif.done_o), 0);
      chk("brw_ptr", 32'(cif.wr_ptr_o), 5);
      chk("brw_res", 32'(cif.result_o), 5);
      press(4'h3);
      chk("brw_hold", 32'(cif.error_o), 3);
      press(4'hF);
      chk("brw_clr", 32'(cif.error_o), 0);
      chk("brw_clr_busy", 32'(cif.busy_o), 0);
      chk("brw_clr_disp", 32'(cif.disp_value_o), 0);
`ifdef CALC_FLAGS_EN
      chk("brw_clr_carry", 32'(carry_o), 0);
`endif

      num(12345);
      chk("ovf_err", 32'(cif.error_o), 1);
      chk("ovf_disp", 32'(cif.disp_value_o), 1234);
      press(4'hA);
      chk("ovf_ign_err", 32'(cif.error_o), 1);
      chk("ovf_ign_disp", 32'(cif.disp_value_o), 1234);
      press(4'hF);
      chk("ovf_clr", 32'(cif.error_o), 0);

      calc(6, 4'hB, 6);
      expect_wb("zero", 0, 6);
`ifdef CALC_FLAGS_EN
      chk("zero_z", 32'(zero_o), 1);
      chk("zero_c", 32'(carry_o), 0);
`endif

      do_reset();
      chk("rst2_ptr", 32'(cif.wr_ptr_o), 0);
      for (int k = 0; k < 9; k++) begin
         calc(1, 4'hA, 1);
         expect_wb($sformatf("wrap%0d", k), 2, (k + 1) % 8);
      end
      rd_chk("wrap_rf0", 3'd0, 2);
      rd_chk("wrap_rf7", 3'd7, 2);

      // abort mid-EXEC with reset
      calc(7, 4'hC, 3);
      chk("abort_busy", 32'(cif.busy_o), 1);
      reset_i = 1'b0;
      #1;
      chk("abort_busy0", 32'(cif.busy_o), 0);
      chk("abort_done", 32'(cif.done_o), 0);
      chk("abort_res", 32'(cif.result_o), 0);
      chk("abort_ptr", 32'(cif.wr_ptr_o), 0);
      chk("abort_rd", 32'(cif.rd_data_o), 0);
      @(negedge clk);
      reset_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("abort_nodone", 32'(cif.done_o), 0);
      end
      rd_chk("abort_rf0", 3'd0, 0);
      rd_chk("abort_rf1", 3'd1, 0);
      chk("abort_ptr2", 32'(cif.wr_ptr_o), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/calc_engine.md
CALC_ENGINE -- requirements
Module: calc_engine

Interface
REQ-001 Parameter WIDTH, default 16, operand/result/register width in bits (legal 8..32).
REQ-002 Parameter NUM_REGS, default 8, result register-file depth (power of two, 2..32).
REQ-003 Parameter DIGITS, default 4, maximum decimal digits per operand (1..9).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset_i  input  1  asynchronous, active-low reset.
REQ-006 key_valid_i  input  1  one-cycle strobe qualifying key_code_i.
REQ-007 key_code_i  input  4  0x0-0x9 digit, 0xA add, 0xB sub, 0xC and, 0xD or, 0xE equals, 0xF clear.
REQ-008 rd_addr_i  input  $clog2(NUM_REGS)  register-file read address.
REQ-009 rd_data_o  output  WIDTH  registered read data.
REQ-010 disp_value_o  output  WIDTH  value for display: entry in progress or last result.
REQ-011 result_o  output  WIDTH  last written result.
REQ-012 done_o  output  1  one-cycle pulse when a result is written.
REQ-013 busy_o  output  1  high in EXEC and WB.
REQ-014 wr_ptr_o  output  $clog2(NUM_REGS)  next register-file write slot.
REQ-015 error_o  output  3  0 none, 1 operand overflow, 2 operator without operand A, 3 arithmetic overflow/borrow, 4 equals without operand B.

Function
REQ-016 FSM states OPA, OPB, EXEC, WB, ERR; reset state OPA.
REQ-017 Digit key in OPA/OPB: entry <= entry*10 + digit, digit count +1.
REQ-018 Digit making count > DIGITS or value > 2^WIDTH-1: go ERR, error_o=1, entry unchanged.
REQ-019 Operator key (A-D) in OPA with count>0: latch A and op, clear entry, go OPB; with count=0: ERR, error_o=2.
REQ-020 Operator key in OPB replaces latched op, entry unaffected.
REQ-021 Equals in OPB with count>0: latch B, go EXEC; count=0: ERR, error_o=4; equals in OPA ignored.
REQ-022 EXEC (one cycle): add/sub WIDTH+1 bits; and/or bitwise; carry out of add or borrow of sub -> ERR, error_o=3, nothing written.
REQ-023 WB (one cycle): regfile[wr_ptr] <= result, result_o <= result, done_o=1, wr_ptr <= wr_ptr+1 mod NUM_REGS (wraps NUM_REGS-1 -> 0), go OPA with entry cleared.
REQ-024 Latency: equals strobe in cycle t -> done_o high in cycle t+2.
REQ-025 Keys during EXEC/WB discarded, no state change.
REQ-026 Clear key (0xF) in any state except EXEC/WB: entry, count, A, B, op, error_o cleared, go OPA; result_o, regfile, wr_ptr kept.
REQ-027 ERR: every key except clear ignored; error_o held.
REQ-028 disp_value_o = entry in OPA/OPB, result_o otherwise.
REQ-029 rd_data_o <= regfile[rd_addr_i] each cycle (1-cycle latency); read of slot written same cycle returns old data.

Reset
REQ-030 reset_i low asynchronously clears FSM to OPA, entry, count, A, B, op, result_o, rd_data_o, wr_ptr_o, error_o, done_o, busy_o, all register-file entries to 0.
REQ-031 Reset asserted mid-EXEC/WB aborts the operation; no write occurs.
REQ-032 Outputs leave reset values only on the first rising edge after reset_i deasserts.

Configuration
REQ-033 Macro CALC_FLAGS_EN defined: extra outputs carry_o (1) and zero_o (1), updated in EXEC (carry/borrow bit, result==0), held otherwise, reset 0, cleared by clear key.
REQ-034 CALC_FLAGS_EN undefined: carry_o/zero_o ports and logic absent; all other behaviour identical.

Verification
REQ-035 Keys 1,2,A,3,E (WIDTH=16) -> done_o two cycles after E, result_o=15, regfile[0]=15, wr_ptr_o=1.
REQ-036 Keys 5,B,9,E -> error_o=3, no done_o, wr_ptr_o unchanged; then F -> error_o=0, state OPA.
REQ-037 DIGITS=4: keys 1,2,3,4,5 -> error_o=1 after fifth digit, disp_value_o=1234; A key ignored until F.
REQ-038 NUM_REGS=8: nine successive 1 A 1 E sequences -> wr_ptr_o wraps 7->0, regfile[0]=2 overwritten, rd_addr_i=0 returns 2 one cycle later.
REQ-039 reset_i low during EXEC of 7 C 3 E -> no done_o, all outputs 0 immediately, regfile unchanged at 0.
REQ-040 CALC_FLAGS_EN defined: 6 B 6 E -> result_o=0, zero_o=1, carry_o=0.
